// File: rtl/cmd_pkg.sv
// Shared types and constants for the command encoder.
// Frame/response lengths switch on macro CMD_ENCODE_CHECKSUM_EN.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE,
    RX,
    DONE
  } cmd_state_e;

  localparam logic [7:0] CMD_HDR_DEFAULT = 8'h81;

  localparam int FRAME_BYTES_PLAIN = 9;
  localparam int FRAME_BYTES_CSUM  = 10;
  localparam int RSP_BYTES_PLAIN   = 8;
  localparam int RSP_BYTES_CSUM    = 9;

`ifdef CMD_ENCODE_CHECKSUM_EN
  localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
  localparam int RSP_BYTES   = RSP_BYTES_CSUM;
`else
  localparam int FRAME_BYTES = FRAME_BYTES_PLAIN;
  localparam int RSP_BYTES   = RSP_BYTES_PLAIN;
`endif

  function automatic logic [7:0] xor_bytes(input logic [63:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ w[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Loadable down-counter; tc_o flags that the loaded interval has fully elapsed.
module cmd_timeout #(
  parameter int unsigned W          = 8,
  parameter int unsigned LOAD_VALUE = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LOAD_V = W'(LOAD_VALUE);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_V;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/cmd_encode.sv
// Sends a header + 64-bit command over a byte transmitter and assembles the
// byte response. Optional XOR checksum byte on both directions: CMD_ENCODE_CHECKSUM_EN.
module cmd_encode
  import cmd_pkg::*;
#(
  parameter logic [7:0]  CMD_HDR        = CMD_HDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [63:0] iCMD_DATA,
  input  logic        iCMD_Start,
  output logic        oCMD_Busy,
  output logic [7:0]  oTXD_DATA,
  output logic        oTXD_Start,
  input  logic        iTXD_Done,
  input  logic [7:0]  iRXD_DATA,
  input  logic        iRXD_Ready,
  output logic [63:0] oRSP_DATA,
  output logic        oRSP_Valid,
  output logic        oRSP_ERR
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] LAST_TX = 4'(FRAME_BYTES - 1);
  localparam logic [3:0] LAST_RX = 4'(RSP_BYTES - 1);

  cmd_state_e  state_q, state_d;
  logic [63:0] cmd_q, cmd_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  txd_data_q, txd_data_d;
  logic        txd_start_q, txd_start_d;
  logic [63:0] rsp_shift_q, rsp_shift_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        tmr_load, tmr_tc;
  logic [7:0]  tx_byte;

`ifdef CMD_ENCODE_CHECKSUM_EN
  logic [7:0] tx_csum_q, tx_csum_d;
  logic [7:0] rx_csum_q, rx_csum_d;
  logic       csum_bad_q, csum_bad_d;
`endif

  // cmd_q shifts left after each data byte, so the next data byte is always [63:56].
  always_comb begin
    tx_byte = cmd_q[63:56];
    if (byte_cnt_q == 4'd0) begin
      tx_byte = CMD_HDR;
    end
`ifdef CMD_ENCODE_CHECKSUM_EN
    else if (byte_cnt_q == 4'd9) begin
      tx_byte = tx_csum_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    byte_cnt_d  = byte_cnt_q;
    txd_data_d  = txd_data_q;
    txd_start_d = 1'b0;
    rsp_shift_d = rsp_shift_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    tmr_load    = 1'b0;
`ifdef CMD_ENCODE_CHECKSUM_EN
    tx_csum_d   = tx_csum_q;
    rx_csum_d   = rx_csum_q;
    csum_bad_d  = csum_bad_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (iCMD_Start) begin
          cmd_d       = iCMD_DATA;
          byte_cnt_d  = 4'd0;
          rsp_err_d   = 1'b0;
          rsp_shift_d = 64'h0;
          state_d     = TX_LOAD;
`ifdef CMD_ENCODE_CHECKSUM_EN
          tx_csum_d   = xor_bytes(iCMD_DATA);
          rx_csum_d   = 8'h00;
          csum_bad_d  = 1'b0;
`endif
        end
      end

      TX_LOAD: begin
        if (iTXD_Done) begin
          txd_data_d  = tx_byte;
          txd_start_d = 1'b1;
          state_d     = TX_WAIT_BUSY;
        end
      end

      TX_WAIT_BUSY: begin
        if (!iTXD_Done) begin
          state_d = TX_WAIT_IDLE;
        end
      end

      TX_WAIT_IDLE: begin
        if (iTXD_Done) begin
          if (byte_cnt_q == LAST_TX) begin
            byte_cnt_d = 4'd0;
            tmr_load   = 1'b1;
            state_d    = RX;
          end else begin
            if (byte_cnt_q != 4'd0) begin
              cmd_d = {cmd_q[55:0], 8'h00};
            end
            byte_cnt_d = byte_cnt_q + 4'd1;
            state_d    = TX_LOAD;
          end
        end
      end

      RX: begin
        // A byte arriving on the timeout cycle takes priority and restarts the timer.
        if (iRXD_Ready) begin
          tmr_load   = 1'b1;
          byte_cnt_d = byte_cnt_q + 4'd1;
`ifdef CMD_ENCODE_CHECKSUM_EN
          if (byte_cnt_q < 4'd8) begin
            rsp_shift_d = {rsp_shift_q[55:0], iRXD_DATA};
            rx_csum_d   = rx_csum_q ^ iRXD_DATA;
          end else begin
            csum_bad_d  = (iRXD_DATA != rx_csum_q);
          end
`else
          rsp_shift_d = {rsp_shift_q[55:0], iRXD_DATA};
`endif
          if (byte_cnt_q == LAST_RX) begin
            state_d = DONE;
          end
        end else if (tmr_tc) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = rsp_shift_q;
          byte_cnt_d = 4'd0;
          state_d    = IDLE;
        end
      end

      DONE: begin
        rsp_data_d = rsp_shift_q;
        byte_cnt_d = 4'd0;
`ifdef CMD_ENCODE_CHECKSUM_EN
        if (csum_bad_q) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
`else
        rsp_valid_d = 1'b1;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      cmd_q       <= 64'h0;
      byte_cnt_q  <= 4'd0;
      txd_data_q  <= 8'h00;
      txd_start_q <= 1'b0;
      rsp_shift_q <= 64'h0;
      rsp_data_q  <= 64'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef CMD_ENCODE_CHECKSUM_EN
      tx_csum_q   <= 8'h00;
      rx_csum_q   <= 8'h00;
      csum_bad_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      byte_cnt_q  <= byte_cnt_d;
      txd_data_q  <= txd_data_d;
      txd_start_q <= txd_start_d;
      rsp_shift_q <= rsp_shift_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef CMD_ENCODE_CHECKSUM_EN
      tx_csum_q   <= tx_csum_d;
      rx_csum_q   <= rx_csum_d;
      csum_bad_q  <= csum_bad_d;
`endif
    end
  end

  cmd_timeout #(
    .W          (TMO_W),
    .LOAD_VALUE (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk_i  (iCLK),
    .rst_ni (iRST_n),
    .load_i (tmr_load),
    .en_i   (state_q == RX),
    .tc_o   (tmr_tc)
  );

  assign oCMD_Busy  = (state_q != IDLE);
  assign oTXD_DATA  = txd_data_q;
  assign oTXD_Start = txd_start_q;
  assign oRSP_DATA  = rsp_data_q;
  assign oRSP_Valid = rsp_valid_q;
  assign oRSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_cmd_encode.sv
// Bench for cmd_encode: transmitter model, randomized commands/responses,
// timeout and mid-frame reset; CMD_ENCODE_CHECKSUM_EN adds checksum bytes.
module tb_cmd_encode;

  localparam int TMO = 100;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [63:0] iCMD_DATA = 64'h0;
  logic        iCMD_Start = 1'b0;
  logic        oCMD_Busy;
  logic [7:0]  oTXD_DATA;
  logic        oTXD_Start;
  logic        iTXD_Done = 1'b1;
  logic [7:0]  iRXD_DATA = 8'h00;
  logic        iRXD_Ready = 1'b0;
  logic [63:0] oRSP_DATA;
  logic        oRSP_Valid;
  logic        oRSP_ERR;

  always #5 iCLK = ~iCLK;

  cmd_encode #(.CMD_HDR(8'h81), .TIMEOUT_CYCLES(TMO)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iCMD_DATA(iCMD_DATA), .iCMD_Start(iCMD_Start),
    .oCMD_Busy(oCMD_Busy), .oTXD_DATA(oTXD_DATA), .oTXD_Start(oTXD_Start),
    .iTXD_Done(iTXD_Done), .iRXD_DATA(iRXD_DATA), .iRXD_Ready(iRXD_Ready),
    .oRSP_DATA(oRSP_DATA), .oRSP_Valid(oRSP_Valid), .oRSP_ERR(oRSP_ERR)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transmitter model: every strobe captures a byte and goes busy for 10 cycles.
  logic [7:0] tx_q[$];
  int tx_busy_cnt = 0;
  int valid_cnt = 0;

  always @(negedge iCLK) begin
    if (oRSP_Valid) valid_cnt++;
    if (oTXD_Start) begin
      tx_q.push_back(oTXD_DATA);
      iTXD_Done = 1'b0;
      tx_busy_cnt = 10;
    end else if (tx_busy_cnt > 0) begin
      tx_busy_cnt--;
      if (tx_busy_cnt == 0) iTXD_Done = 1'b1;
    end
  end

  logic [7:0] exp_q[$];

  task automatic send_cmd(input logic [63:0] d);
    @(negedge iCLK);
    iCMD_DATA = d;
    iCMD_Start = 1'b1;
    @(negedge iCLK);
    iCMD_Start = 1'b0;
    iCMD_DATA = {$urandom, $urandom};
    check_eq("accept_busy", 64'(oCMD_Busy), 64'd1);
    check_eq("accept_err_clr", 64'(oRSP_ERR), 64'd0);
    check_eq("latency_not_yet", 64'(oTXD_Start), 64'd0);
    @(negedge iCLK);
    check_eq("latency_start", 64'(oTXD_Start), 64'd1);
    check_eq("latency_hdr", 64'(oTXD_DATA), 64'h81);
  endtask

  task automatic wait_frame(input logic [63:0] d, input string tag);
    int cyc;
    logic [7:0] cs;
    exp_q.delete();
    exp_q.push_back(8'h81);
    cs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[63 - 8*i -: 8]);
      cs = cs ^ d[63 - 8*i -: 8];
    end
`ifdef CMD_ENCODE_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    cyc = 0;
    while (tx_q.size() < exp_q.size() && cyc < 2000) begin
      @(negedge iCLK);
      cyc++;
    end
    if (cyc >= 2000) check_eq({tag, "_tx_wait"}, 64'(tx_q.size()), 64'(exp_q.size()));
    repeat (15) @(negedge iCLK);
    check_eq({tag, "_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i),
               (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hx, 64'(exp_q[i]));
    end
    tx_q.delete();
  endtask

  task automatic send_rsp_byte(input logic [7:0] b);
    @(negedge iCLK);
    iRXD_DATA = b;
    iRXD_Ready = 1'b1;
    @(negedge iCLK);
    iRXD_Ready = 1'b0;
  endtask

  task automatic do_rsp(input string tag, input bit fixed, input bit poke);
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [63:0] exp;
    int v0;
    int cyc;
    exp = 64'h0;
    cs = 8'h00;
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      exp = (exp << 8) | 64'(b);
      cs = cs ^ b;
      repeat ($urandom_range(0, 4)) @(negedge iCLK);
      send_rsp_byte(b);
      if (poke && i == 3) begin
        @(negedge iCLK);
        iCMD_Start = 1'b1;
        iCMD_DATA = 64'hDEAD_BEEF_0000_FFFF;
        @(negedge iCLK);
        iCMD_Start = 1'b0;
      end
    end
`ifdef CMD_ENCODE_CHECKSUM_EN
    send_rsp_byte(cs);
`endif
    cyc = 0;
    while (!oRSP_Valid && cyc < 20) begin
      @(negedge iCLK);
      cyc++;
    end
    check_eq({tag, "_valid"}, 64'(oRSP_Valid), 64'd1);
    check_eq({tag, "_data"}, oRSP_DATA, exp);
    repeat (5) @(negedge iCLK);
    check_eq({tag, "_valid_once"}, 64'(valid_cnt - v0), 64'd1);
    check_eq({tag, "_busy_low"}, 64'(oCMD_Busy), 64'd0);
    check_eq({tag, "_err_low"}, 64'(oRSP_ERR), 64'd0);
    check_eq({tag, "_data_held"}, oRSP_DATA, exp);
    check_eq({tag, "_no_tx"}, 64'(tx_q.size()), 64'd0);
    $display("TXN %s rsp=%h", tag, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_txd_start"}, 64'(oTXD_Start), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(oRSP_Valid), 64'd0);
    check_eq({tag, "_busy"}, 64'(oCMD_Busy), 64'd0);
    check_eq({tag, "_err"}, 64'(oRSP_ERR), 64'd0);
    check_eq({tag, "_txd_data"}, 64'(oTXD_DATA), 64'h0);
    check_eq({tag, "_rsp_data"}, oRSP_DATA, 64'h0);
  endtask

  initial begin
    logic [63:0] d;
    int cyc;
    int v0;

    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (3) @(negedge iCLK);

    // Fixed frame and response.
    d = 64'h0123_4567_89AB_CDEF;
    send_cmd(d);
    wait_frame(d, "fixed");
    do_rsp("fixed", 1'b1, 1'b0);

    // Start and stray RX bytes while transmitting, start again while receiving.
    d = 64'hA5A5_0F0F_3C3C_9669;
    send_cmd(d);
    cyc = 0;
    while (tx_q.size() < 3 && cyc < 500) begin
      @(negedge iCLK);
      cyc++;
    end
    iCMD_Start = 1'b1;
    iCMD_DATA = ~d;
    iRXD_DATA = 8'h5A;
    iRXD_Ready = 1'b1;
    @(negedge iCLK);
    iCMD_Start = 1'b0;
    iRXD_Ready = 1'b0;
    wait_frame(d, "ignore");
    do_rsp("ignore", 1'b0, 1'b1);

    // Timeout after three response bytes.
    d = {$urandom, $urandom};
    send_cmd(d);
    wait_frame(d, "tmo");
    send_rsp_byte(8'h12);
    send_rsp_byte(8'h34);
    repeat (7) @(negedge iCLK);
    send_rsp_byte(8'h56);
    v0 = valid_cnt;
    repeat (TMO - 1) @(posedge iCLK);
    @(negedge iCLK);
    check_eq("tmo_err_early", 64'(oRSP_ERR), 64'd0);
    check_eq("tmo_busy_early", 64'(oCMD_Busy), 64'd1);
    @(posedge iCLK);
    @(negedge iCLK);
    check_eq("tmo_err", 64'(oRSP_ERR), 64'd1);
    check_eq("tmo_busy", 64'(oCMD_Busy), 64'd0);
    repeat (5) @(negedge iCLK);
    check_eq("tmo_no_valid", 64'(valid_cnt - v0), 64'd0);
    check_eq("tmo_err_held", 64'(oRSP_ERR), 64'd1);
    $display("TXN tmo data=%h", d);

    // Randomized transactions.
    for (int t = 0; t < 4; t++) begin
      d = {$urandom, $urandom};
      send_cmd(d);
      wait_frame(d, $sformatf("rnd%0d", t));
      do_rsp($sformatf("rnd%0d", t), 1'b0, 1'b0);
    end

    // Reset after the fourth byte, then a complete fresh frame.
    d = {$urandom, $urandom};
    send_cmd(d);
    cyc = 0;
    while (tx_q.size() < 4 && cyc < 500) begin
      @(negedge iCLK);
      cyc++;
    end
    check_eq("rst_reached_b4", 64'(tx_q.size() >= 4), 64'd1);
    iRST_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tx_q.delete();
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (15) @(negedge iCLK);
    check_eq("rst_not_resumed", 64'(tx_q.size()), 64'd0);
    check_eq("rst_busy_idle", 64'(oCMD_Busy), 64'd0);
    d = {$urandom, $urandom};
    send_cmd(d);
    wait_frame(d, "post_rst");
    do_rsp("post_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/cmd_encode.md
CMD_ENCODE -- requirements
Module: cmd_encode

Interface
REQ-001 Parameter CMD_HDR, default 8'h81, header byte sent first in every command frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000, response timeout in iCLK cycles (1 s at 50 MHz).
REQ-003 iCLK  in  1  single clock, 50 MHz (OSC_50).
REQ-004 iRST_n  in  1  asynchronous active-low reset.
REQ-005 iCMD_DATA  in  64  command word; sampled only on an accepted iCMD_Start.
REQ-006 iCMD_Start  in  1  one-cycle request to send iCMD_DATA.
REQ-007 oCMD_Busy  out  1  high from accept until oRSP_Valid or error.
REQ-008 oTXD_DATA  out  8  byte to the RS232 transmitter.
REQ-009 oTXD_Start  out  1  one-cycle transmit strobe.
REQ-010 iTXD_Done  in  1  transmitter idle level (inverse of TX busy).
REQ-011 iRXD_DATA  in  8  received byte.
REQ-012 iRXD_Ready  in  1  one-cycle strobe, iRXD_DATA valid.
REQ-013 oRSP_DATA  out  64  assembled response word; held until the next accepted iCMD_Start.
REQ-014 oRSP_Valid  out  1  one-cycle pulse, response complete and correct.
REQ-015 oRSP_ERR  out  1  level, last transaction failed; cleared on next accepted iCMD_Start.

Function
REQ-016 States: IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE, RX, DONE.
REQ-017 IDLE: iCMD_Start accepted only in IDLE; latch iCMD_Data, clear byte counter, clear oRSP_ERR, go TX_LOAD next cycle.
REQ-018 iCMD_Start outside IDLE is ignored with no side effect.
REQ-019 Frame order: CMD_HDR, then iCMD_DATA bytes [63:56] down to [7:0] (MSB first); 9 bytes total.
REQ-020 TX_LOAD: wait for iTXD_Done=1, drive oTXD_DATA and pulse oTXD_Start one cycle, go TX_WAIT_BUSY.
REQ-021 TX_WAIT_BUSY: wait for iTXD_Done=0, then go TX_WAIT_IDLE. oTXD_DATA holds stable through this state.
REQ-022 TX_WAIT_IDLE: on iTXD_Done=1, go TX_LOAD if bytes remain, else clear counters and go RX.
REQ-023 RX: each iRXD_Ready shifts iRXD_DATA into the response LSB (first byte ends up at [63:56]). After 8 bytes, go DONE.
REQ-024 iRXD_Ready outside RX is discarded.
REQ-025 Timeout counter runs only in RX and reloads on every received byte. On reaching TIMEOUT_CYCLES-1, set oRSP_ERR, drop oCMD_Busy, go IDLE; oRSP_DATA keeps its partial contents.
REQ-026 DONE: copy the shift register to oRSP_DATA, pulse oRSP_Valid one cycle, drop oCMD_Busy, go IDLE; total one cycle.
REQ-027 iRXD_Ready on the same cycle as a timeout: the byte wins and the counter reloads.
REQ-028 Minimum latency from iCMD_Start to the first oTXD_Start is 2 cycles when iTXD_Done=1.

Reset
REQ-029 On iRST_n=0, all of the following apply immediately, mid-frame included:
- state=IDLE.
- oTXD_Start=0, oRSP_Valid=0, oCMD_Busy=0, oRSP_ERR=0.
- oTXD_DATA=8'h00, oRSP_DATA=64'h0.
- all counters 0.
REQ-030 A partially sent frame is abandoned and is not resumed after reset.

Configuration
REQ-031 With macro CMD_ENCODE_CHECKSUM_EN defined, the frame gets a 10th byte: XOR of the 8 data bytes, with the header excluded.
REQ-032 With CMD_ENCODE_CHECKSUM_EN defined, the response is 9 bytes, and the 9th byte is the XOR of the first 8. On mismatch, set oRSP_ERR and suppress oRSP_VALID.
REQ-033 Without CMD_ENCODE_CHECKSUM_EN, the frame is 9 bytes, the response is 8 bytes, and no checksum logic exists.

Structure
REQ-034 Shared package cmd_pkg holds:
- the state enum;
- CMD_HDR_DEFAULT;
- frame and response byte-count constants, both checksum variants.
REQ-035 The sub-module cmd_timeout holds the loadable down-counter with a terminal-count flag. All other logic stays in cmd_encode.

Verification
REQ-036 Scenario: iCMD_DATA=64'h0123_4567_89AB_CDEF, TX model with 10-cycle busy -> bytes 81,01,23,45,67,89,AB,CD,EF in that order, one oTXD_Start each.
REQ-037 Scenario: after the frame, feed response bytes 11..88 -> oRSP_DATA=64'h1122_3344_5566_7788 and oRSP_Valid pulses exactly once.
REQ-038 Scenario: only 3 response bytes, TIMEOUT_CYCLES=100 -> oRSP_ERR=1 and oCMD_Busy=0 exactly 100 cycles after the 3rd byte; no oRSP_Valid.
REQ-039 Scenario: iCMD_Start pulsed again during TX and during RX -> ignored; frame unchanged.
REQ-040 Scenario: iRST_n low after the 4th byte -> all outputs at reset values, state IDLE; a new command then sends a full frame starting with 81.
REQ-041 Scenario (CMD_ENCODE_CHECKSUM_EN): data 64'h0123_4567_89AB_CDEF -> checksum byte 00 sent; response with a bad checksum -> oRSP_ERR=1 and no oRSP_Valid.
